exec_stage: RTL

- Execute stage of the 5-stage ARM pipeline; consumes the Decode/Execute register outputs (RD1E, RD2E, ExtendE, InstrE, RA1E, RA2E) and feeds the Execute/Memory register.
- Performs operand forwarding, the ALU operation, condition evaluation against an internal NZCV flags register, and an iterative multi-cycle MUL.
- While a MUL is in progress it raises stall_req to the hazard unit.

---
 rtl/exec_pkg.sv | 42 ++++
 rtl/exec_stage_mul_iter.sv | 107 ++++++++++
 rtl/exec_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the Execute stage: ALU opcodes, MUL FSM
// states, ARM condition codes and the MUL opcode match pattern.
package exec_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    ORR = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] NE = 4'b0001;
  localparam logic [3:0] CS = 4'b0010;
  localparam logic [3:0] CC = 4'b0011;
  localparam logic [3:0] MI = 4'b0100;
  localparam logic [3:0] PL = 4'b0101;
  localparam logic [3:0] VS = 4'b0110;
  localparam logic [3:0] VC = 4'b0111;
  localparam logic [3:0] HI = 4'b1000;
  localparam logic [3:0] LS = 4'b1001;
  localparam logic [3:0] GE = 4'b1010;
  localparam logic [3:0] LT = 4'b1011;
  localparam logic [3:0] GT = 4'b1100;
  localparam logic [3:0] LE = 4'b1101;
  localparam logic [3:0] AL = 4'b1110;

  // MUL encoding: Instr[27:22] and Instr[7:4]
  localparam logic [5:0] MUL_OP_HI = 6'b000000;
  localparam logic [3:0] MUL_OP_LO = 4'b1001;

  function automatic logic is_mul_instr(input logic [5:0] op_hi, input logic [3:0] op_lo);
    return (op_hi == MUL_OP_HI) && (op_lo == MUL_OP_LO);
  endfunction

endpackage

// File: rtl/exec_stage_mul_iter.sv
// Iterative shift-add multiplier with IDLE/BUSY/DONE control. Retires
// MUL_BITS multiplier bits per BUSY cycle; only the low 32 product bits kept.
module mul_iter
  import exec_pkg::*;
#(
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_e,
  input  logic        advance_e,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] product,
  output logic        stall_req,
  output logic        mul_busy,
  output logic        mul_done
);

  localparam int N = 32 / MUL_BITS;
  localparam logic [5:0] CNT_LAST = 6'(N - 1);

  mul_state_t  state_r;
  mul_state_t  state_nxt_s;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] acc_r;
  logic [5:0]  cnt_r;
  logic [31:0] partial_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; reset or flush forces IDLE from any state
  always_comb begin
    state_nxt_s = state_r;
    if (reset || flush_e) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = start ? BUSY : IDLE;
        BUSY:    state_nxt_s = (cnt_r == CNT_LAST) ? DONE : BUSY;
        DONE:    state_nxt_s = advance_e ? IDLE : DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Outputs; the issue cycle already stalls so the MUL cannot retire early
  always_comb begin
    stall_req = 1'b0;
    mul_busy  = 1'b0;
    mul_done  = 1'b0;
    if (reset || flush_e) begin
      stall_req = 1'b0;
    end else begin
      case (state_r)
        IDLE:    stall_req = start;
        BUSY: begin
          stall_req = 1'b1;
          mul_busy  = 1'b1;
        end
        DONE:    mul_done = 1'b1;
        default: stall_req = 1'b0;
      endcase
    end
  end

  // Partial product for the MUL_BITS low multiplier bits of this step
  always_comb begin
    partial_s = 32'd0;
    for (int i = 0; i < MUL_BITS; i++) begin
      partial_s = partial_s + (b_r[i] ? (a_r << i) : 32'd0);
    end
  end

  // Operand capture at issue, then shift-add accumulation while BUSY
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      acc_r <= 32'd0;
      cnt_r <= 6'd0;
    end else if ((state_r == IDLE) && start) begin
      a_r   <= op_a;
      b_r   <= op_b;
      acc_r <= 32'd0;
      cnt_r <= 6'd0;
    end else if (state_r == BUSY) begin
      acc_r <= acc_r + partial_s;
      a_r   <= a_r << MUL_BITS;
      b_r   <= b_r >> MUL_BITS;
      cnt_r <= cnt_r + 6'd1;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  assign product = acc_r;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand forwarding, ALU, condition check against the NZCV
// register, flag update on retire, and the iterative MUL unit.
module exec_stage
  import exec_pkg::*;
#(
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_e,
  input  logic        advance_e,
  input  logic        valid_e,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ExtendE,
  input  logic [31:0] InstrE,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] ResultW,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ALUControlE,
  input  logic [1:0]  FlagWriteE,
  output logic [31:0] ALUResultE,
  output logic [31:0] WriteDataE,
  output logic        CondExE,
  output logic [3:0]  FlagsE,
  output logic        stall_req,
  output logic        mul_busy
);

  logic [31:0] src_a_s;
  logic [31:0] fwd_b_s;
  logic [31:0] src_b_s;
  alu_op_t     alu_op_s;
  logic [31:0] b_in_s;
  logic [32:0] sum_s;
  logic [31:0] alu_res_s;
  logic        alu_c_s;
  logic        alu_v_s;
  logic        cond_pass_s;
  logic        is_mul_s;
  logic        mul_start_s;
  logic        mul_done_s;
  logic [31:0] product_s;
  logic        retire_s;
  logic [3:0]  flags_r;
  logic [3:0]  flags_nxt_s;
  logic        flag_n_s, flag_z_s, flag_c_s, flag_v_s;
  logic        unused_instr_s;

  assign unused_instr_s = ^{InstrE[21:8], InstrE[3:0]};
  assign {flag_n_s, flag_z_s, flag_c_s, flag_v_s} = flags_r;

  // Operand forwarding; 11 falls back to the register file
  always_comb begin
    case (ForwardAE)
      2'b10:   src_a_s = ALUResultM;
      2'b01:   src_a_s = ResultW;
      default: src_a_s = RD1E;
    endcase
    case (ForwardBE)
      2'b10:   fwd_b_s = ALUResultM;
      2'b01:   fwd_b_s = ResultW;
      default: fwd_b_s = RD2E;
    endcase
    src_b_s = ALUSrcE ? ExtendE : fwd_b_s;
  end

  assign WriteDataE = fwd_b_s;

  // ALU: SUB is A + ~B + 1 so carry and overflow share the adder path
  always_comb begin
    alu_op_s  = alu_op_t'(ALUControlE);
    b_in_s    = src_b_s;
    sum_s     = 33'd0;
    alu_res_s = 32'd0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (alu_op_s)
      ADD, SUB: begin
        b_in_s    = (alu_op_s == SUB) ? ~src_b_s : src_b_s;
        sum_s     = {1'b0, src_a_s} + {1'b0, b_in_s} + {32'd0, (alu_op_s == SUB)};
        alu_res_s = sum_s[31:0];
        alu_c_s   = sum_s[32];
        alu_v_s   = (src_a_s[31] == b_in_s[31]) && (alu_res_s[31] != src_a_s[31]);
      end
      AND:     alu_res_s = src_a_s & src_b_s;
      ORR:     alu_res_s = src_a_s | src_b_s;
      default: alu_res_s = 32'd0;
    endcase
  end

  // ARM condition decode against the current flags; 1111 never passes
  always_comb begin
    case (InstrE[31:28])
      EQ:      cond_pass_s = flag_z_s;
      NE:      cond_pass_s = !flag_z_s;
      CS:      cond_pass_s = flag_c_s;
      CC:      cond_pass_s = !flag_c_s;
      MI:      cond_pass_s = flag_n_s;
      PL:      cond_pass_s = !flag_n_s;
      VS:      cond_pass_s = flag_v_s;
      VC:      cond_pass_s = !flag_v_s;
      HI:      cond_pass_s = flag_c_s && !flag_z_s;
      LS:      cond_pass_s = !flag_c_s || flag_z_s;
      GE:      cond_pass_s = (flag_n_s == flag_v_s);
      LT:      cond_pass_s = (flag_n_s != flag_v_s);
      GT:      cond_pass_s = !flag_z_s && (flag_n_s == flag_v_s);
      LE:      cond_pass_s = flag_z_s || (flag_n_s != flag_v_s);
      AL:      cond_pass_s = 1'b1;
      default: cond_pass_s = 1'b0;
    endcase
  end

  assign CondExE     = cond_pass_s & valid_e;
  assign is_mul_s    = is_mul_instr(InstrE[27:22], InstrE[7:4]);
  assign mul_start_s = CondExE & is_mul_s;

  mul_iter #(
    .MUL_BITS (MUL_BITS)
  ) u_mul_iter (
    .clk       (clk),
    .reset     (reset),
    .flush_e   (flush_e),
    .advance_e (advance_e),
    .start     (mul_start_s),
    .op_a      (src_a_s),
    .op_b      (src_b_s),
    .product   (product_s),
    .stall_req (stall_req),
    .mul_busy  (mul_busy),
    .mul_done  (mul_done_s)
  );

  assign ALUResultE = mul_done_s ? product_s : alu_res_s;
  assign retire_s   = advance_e & valid_e & CondExE & ~stall_req;

  // Candidate flags; a MUL never touches C and V
  always_comb begin
    flags_nxt_s = flags_r;
    if (FlagWriteE[1]) begin
      flags_nxt_s[3:2] = {ALUResultE[31], (ALUResultE == 32'd0)};
    end else begin
      flags_nxt_s[3:2] = flags_r[3:2];
    end
    if (FlagWriteE[0] && !is_mul_s) begin
      flags_nxt_s[1:0] = {alu_c_s, alu_v_s};
    end else begin
      flags_nxt_s[1:0] = flags_r[1:0];
    end
  end

  // NZCV register: cleared by reset, loaded only when an instruction retires
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if (retire_s && !flush_e) begin
      flags_r <= flags_nxt_s;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign FlagsE = flags_r;

endmodule
